// File: rtl/fact_core.sv
// fact_core: iterative factorial engine.
// Accepts an operand on a one-cycle go pulse and computes n! with one DW-bit
// multiply per cycle. Operands above MAX_N are rejected at once with err/done.
// Results and status hold in FIN until the next accepted go or a reset.
module fact_core #(
    parameter int NW    = 8,
    parameter int DW    = 32,
    parameter int MAX_N = 12
) (
    input  logic          clk,
    input  logic          rst,            // synchronous, active-low
    input  logic          go,
    input  logic [NW-1:0] n,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] factorial_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] prod_q,  prod_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          err_q,   err_d;
    logic [DW-1:0] out_q,   out_d;

    // Operand range check is unsigned over the full operand width.
    logic          n_too_big;
    // Running product times counter, truncated to the result width.
    logic [DW-1:0] mul_w;
    // Counter has reached the last factor (covers 0! and 1! as well).
    logic          cnt_last;

    assign n_too_big = (n > NW'(MAX_N));
    assign mul_w     = prod_q * DW'(cnt_q);
    assign cnt_last  = (cnt_q <= NW'(1));

    // Next-state and registered-output computation; every path holds by default.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        out_d   = out_q;

        case (state_q)
            IDLE, FIN: begin
                if (go) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    out_d  = '0;
                    if (n_too_big) begin
                        // Rejected operand: report immediately, never go busy.
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        cnt_d   = n;
                        prod_d  = DW'(1);
                        busy_d  = 1'b1;
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                // go is ignored here; operand is not resampled.
                if (cnt_last) begin
                    out_d   = prod_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    prod_d = mul_w;
                    cnt_d  = cnt_q - NW'(1);
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE without a result.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            out_q   <= out_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign factorial_out = out_q;

endmodule

// File: tb/tb_fact_core.sv
// tb_fact_core: scoreboard bench for fact_core.
// The driver predicts each accepted request from n alone (n!, error flag and the
// edge on which done must appear) and queues it; the monitor checks the DUT
// after every edge against the oldest outstanding request.
module tb_fact_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  n;
    logic        busy, done, err;
    logic [31:0] factorial_out;

    fact_core #(.NW(8), .DW(32), .MAX_N(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .n             (n),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .factorial_out (factorial_out)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  n;
        logic [31:0] val;
        bit          err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_due = 0;

    // Reference model: n! by plain arithmetic, 0 for rejected operands.
    function automatic logic [31:0] ref_fact(input logic [7:0] v);
        longint r = 1;
        if (v > 12) return 32'd0;
        for (int i = 2; i <= int'(v); i++) r = r * i;
        return r[31:0];
    endfunction

    // Edges from the accept edge until done is visible.
    function automatic int ref_lat(input logic [7:0] v);
        if (v > 12) return 0;
        if (v <= 1) return 1;
        return int'(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Drive go for the next edge; queue a prediction only if the engine will take it.
    task automatic issue(input logic [7:0] v);
        exp_t e;
        @(negedge clk);
        go = 1'b1;
        n  = v;
        if (cyc >= last_due) begin
            e.n   = v;
            e.val = ref_fact(v);
            e.err = (v > 12);
            e.due = cyc + 1 + ref_lat(v);
            last_due = e.due;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            go = 1'b0;
            n  = 8'($urandom);
        end
    endtask

    task automatic wait_done();
        int b = 0;
        while (cyc < last_due && b < 300) begin
            idle(1);
            b++;
        end
    endtask

    // Reset with go asserted throughout; reset must win.
    task automatic do_reset(input int k);
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b1;
        n   = 8'd5;
        sb.delete();
        repeat (k) @(negedge clk);
        rst = 1'b1;
        go  = 1'b0;
        last_due = cyc;
    endtask

    // Monitor: sample just after each rising edge, when go/rst still show the edge's values.
    initial begin : monitor
        logic        done_prev = 1'b0;
        logic        err_prev  = 1'b0;
        logic [31:0] out_prev  = '0;
        exp_t        e;
        bit          present;
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b1) begin
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                chk("reset_err", err, 0);
                chk("reset_out", factorial_out, 0);
            end else begin
                chk("busy_done_excl", busy & done, 0);
                present = done && (!done_prev || go);
                if (present) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done @cyc %0d: got done=1 expected no result", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("result", factorial_out, e.val);
                        chk("err_flag", err, e.err);
                        chk("done_cycle", cyc, e.due);
                        chk("busy_at_done", busy, 0);
                    end
                end else if (sb.size() != 0 && cyc >= sb[0].due) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL done_timeout n=%0d @cyc %0d: got done=%0d expected done at cyc %0d",
                             e.n, cyc, done, e.due);
                end else if (sb.size() != 0) begin
                    chk("busy_in_mult", busy, !sb[0].err);
                    chk("done_in_mult", done, 0);
                    chk("err_in_mult", err, 0);
                    chk("out_in_mult", factorial_out, 0);
                end else begin
                    chk("busy_idle", busy, 0);
                    if (done && done_prev) begin
                        chk("hold_out", factorial_out, out_prev);
                        chk("hold_err", err, err_prev);
                    end else if (!done) begin
                        chk("idle_out", factorial_out, 0);
                        chk("idle_err", err, 0);
                    end
                end
            end
            done_prev = (rst === 1'b1) ? done : 1'b0;
            err_prev  = err;
            out_prev  = factorial_out;
        end
    end

    initial begin : driver
        logic [7:0] v;
        int r;
        rst = 1'b0;
        go  = 1'b0;
        n   = 8'd0;
        do_reset(2);
        idle(3);

        // Nominal, then hold stable in FIN.
        issue(8'd5);  wait_done(); idle(20);
        // Boundaries.
        issue(8'd0);  wait_done(); idle(2);
        issue(8'd1);  wait_done(); idle(2);
        issue(8'd12); wait_done(); idle(2);
        // Rejected operands, including back-to-back from FIN.
        issue(8'd13); idle(3);
        issue(8'd255); issue(8'd13); idle(2);
        issue(8'd13); issue(8'd3); wait_done(); idle(1);
        // Ignored go while busy, then restart from FIN.
        issue(8'd6); idle(2); issue(8'd3); wait_done(); idle(2);
        issue(8'd3); wait_done(); idle(2);
        // go on the edge that enters FIN is ignored; the next edge accepts.
        issue(8'd4);
        while (cyc < last_due - 1) idle(1);
        issue(8'd7);
        issue(8'd2); wait_done(); idle(2);
        // Reset mid-computation, then a fresh run.
        issue(8'd10); idle(3);
        do_reset(1);
        issue(8'd4); wait_done(); idle(3);

        // Randomized traffic with ignored pulses and occasional resets.
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       v = 8'($urandom_range(0, 12));
            else if (r == 7) v = 8'($urandom_range(13, 255));
            else if (r == 8) v = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd13;
            else             v = 8'd12;
            issue(v);
            if ($urandom_range(0, 14) == 0) begin
                idle($urandom_range(0, 3));
                do_reset($urandom_range(1, 2));
            end else begin
                while (cyc < last_due) begin
                    if ($urandom_range(0, 3) == 0) issue(8'($urandom));
                    else idle(1);
                end
                idle($urandom_range(0, 3));
            end
        end

        wait_done();
        idle(4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
